// File: rtl/unidade_controle_jogo.sv
// Control unit for the memory game: Moore FSM plus a per-play timeout timer.
// Sequences the address counter (E), sequence counter (S) and play register (R)
// and reports win, loss and timeout.
module unidade_controle_jogo #(
  parameter int unsigned TIMEOUT_CICLOS = 3000,
  parameter int unsigned TW             = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       nivel,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimS_long,
  input  logic       fimS_short,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraS,
  output logic       contaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    Inicial    = 4'h0,
    Preparacao = 4'h1,
    NovaSeq    = 4'h2,
    Espera     = 4'h3,
    Registra   = 4'h4,
    Compara    = 4'h5,
    Proximo    = 4'h6,
    ProxSeq    = 4'h7,
    FimAcerto  = 4'hA,
    FimTimeout = 4'hD,
    FimErro    = 4'hE
  } estado_t;

  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT_CICLOS - 1);

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q;
  logic          nivel_q;
  logic          fim_s;

  assign db_estado = estado_q;

  // Next-state logic; the game length is chosen by the level latched at start.
  always_comb begin
    fim_s    = nivel_q ? fimS_long : fimS_short;
    estado_d = estado_q;
    case (estado_q)
      Inicial:    if (jogar) estado_d = Preparacao;
      Preparacao: estado_d = NovaSeq;
      NovaSeq:    estado_d = Espera;
      Espera: begin
        // A press wins over a timeout landing in the same cycle.
        if (jogada)                  estado_d = Registra;
        else if (timer_q == TimerMax) estado_d = FimTimeout;
      end
      Registra:   estado_d = Compara;
      Compara: begin
        if (!igual)     estado_d = FimErro;
        else if (!fimE) estado_d = Proximo;
        else if (fim_s) estado_d = FimAcerto;
        else            estado_d = ProxSeq;
      end
      Proximo:    estado_d = Espera;
      ProxSeq:    estado_d = NovaSeq;
      FimAcerto, FimErro, FimTimeout: if (jogar) estado_d = Preparacao;
      default:    estado_d = Inicial;
    endcase
  end

  // State, timer, latched level and outputs registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= Inicial;
      timer_q    <= '0;
      nivel_q    <= 1'b0;
      zeraE      <= 1'b0;
      contaE     <= 1'b0;
      zeraS      <= 1'b0;
      contaS     <= 1'b0;
      zeraR      <= 1'b0;
      registraR  <= 1'b0;
      pronto     <= 1'b0;
      ganhou     <= 1'b0;
      perdeu     <= 1'b0;
      db_timeout <= 1'b0;
    end else begin
      estado_q <= estado_d;
      // Timer only runs in espera, so every entry to espera starts from zero.
      if (estado_q == Espera) timer_q <= timer_q + TW'(1);
      else                    timer_q <= '0;
      if (estado_q == Preparacao) nivel_q <= nivel;
      zeraE      <= (estado_d == Preparacao) || (estado_d == NovaSeq);
      zeraS      <= (estado_d == Preparacao);
      zeraR      <= (estado_d == Preparacao);
      registraR  <= (estado_d == Registra);
      contaE     <= (estado_d == Proximo);
      contaS     <= (estado_d == ProxSeq);
      pronto     <= (estado_d == FimAcerto) || (estado_d == FimErro) ||
                    (estado_d == FimTimeout);
      ganhou     <= (estado_d == FimAcerto);
      perdeu     <= (estado_d == FimErro) || (estado_d == FimTimeout);
      db_timeout <= (estado_d == FimTimeout);
    end
  end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo with a small datapath model.
module tb_unidade_controle_jogo;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic jogar = 1'b0, nivel = 1'b0, jogada = 1'b0;
  logic igual, fimE, fimS_long, fimS_short;
  logic zeraE, contaE, zeraS, contaS, zeraR, registraR;
  logic pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;

  int n_chk = 0;
  int n_pass = 0;

  // Datapath model: address/sequence counters driven by the DUT controls.
  logic [3:0] e_q, s_q;
  logic       err_en = 1'b0;
  logic [3:0] err_s = 4'd0, err_e = 4'd0;
  int n_reg = 0, n_cs = 0, n_ce = 0;

  assign fimE       = (e_q == s_q);
  assign fimS_short = (s_q == 4'd3);
  assign fimS_long  = (s_q == 4'd5);
  assign igual      = !(err_en && (s_q == err_s) && (e_q == err_e));

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_q <= 4'd0;
      s_q <= 4'd0;
    end else begin
      if (zeraE) e_q <= 4'd0;
      else if (contaE) e_q <= e_q + 4'd1;
      if (zeraS) s_q <= 4'd0;
      else if (contaS) s_q <= s_q + 4'd1;
    end
  end

  always @(posedge clock) begin
    if (registraR) n_reg <= n_reg + 1;
    if (contaS) n_cs <= n_cs + 1;
    if (contaE) n_ce <= n_ce + 1;
  end

  unidade_controle_jogo #(.TIMEOUT_CICLOS(20), .TW(5)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .nivel(nivel), .jogada(jogada),
    .igual(igual), .fimE(fimE), .fimS_long(fimS_long), .fimS_short(fimS_short),
    .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS), .zeraR(zeraR),
    .registraR(registraR), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );

  // Plays whenever espera has lasted 'delay' cycles (0 = never play) until a final state.
  task automatic run_game(input int delay, input int budget, output logic [3:0] fin,
                          output int esp_max, output int bad);
    int esp;
    esp = 0; fin = 4'h0; esp_max = 0; bad = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (db_estado == 4'hA || db_estado == 4'hE || db_estado == 4'hD) begin
        fin = db_estado;
        break;
      end
      if (db_estado == 4'h3) begin
        esp++;
        if (esp > esp_max) esp_max = esp;
        if (delay != 0 && esp == delay) begin
          jogada = 1'b1;
          @(negedge clock);
          jogada = 1'b0;
          if (db_estado !== 4'h4) bad++;
          esp = 0;
        end
      end else begin
        esp = 0;
      end
    end
  endtask

  task automatic start_game(input logic nv);
    @(negedge clock);
    jogar = 1'b1;
    nivel = nv;
    @(negedge clock);
    jogar = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_st [5];
    exp_st = '{4'h1, 4'h2, 4'h3, 4'h3, 4'h3};
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    n_chk++;
    if (db_estado !== 4'h0) $display("FAIL reset_state: got %h want 0", db_estado);
    else n_pass++;
    n_chk++;
    if ({zeraE, contaE, zeraS, contaS, zeraR, registraR, pronto, ganhou, perdeu, db_timeout}
        !== 10'b0)
      $display("FAIL reset_outputs: got %b want 0", {zeraE, contaE, zeraS, contaS, zeraR,
               registraR, pronto, ganhou, perdeu, db_timeout});
    else n_pass++;
    jogar = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_chk++;
      if (db_estado !== exp_st[i])
        $display("FAIL start_seq[%0d]: got %h want %h", i, db_estado, exp_st[i]);
      else n_pass++;
    end
    jogar = 1'b0;
  endtask

  task automatic test_short_win();
    logic [3:0] fin;
    int esp_max, bad, r0, s0;
    r0 = n_reg; s0 = n_cs;
    run_game(1, 2000, fin, esp_max, bad);
    n_chk++;
    if (fin !== 4'hA) $display("FAIL win_state: got %h want A", fin); else n_pass++;
    n_chk++;
    if ({pronto, ganhou, perdeu, db_timeout} !== 4'b1100)
      $display("FAIL win_flags: got %b want 1100", {pronto, ganhou, perdeu, db_timeout});
    else n_pass++;
    n_chk++;
    if (n_cs - s0 != 3) $display("FAIL win_contaS: got %0d want 3", n_cs - s0); else n_pass++;
    n_chk++;
    if (n_reg - r0 != 10) $display("FAIL win_registraR: got %0d want 10", n_reg - r0);
    else n_pass++;
  endtask

  task automatic test_error();
    logic [3:0] fin;
    int esp_max, bad, r0, e0;
    err_en = 1'b1; err_s = 4'd1; err_e = 4'd1;
    start_game(1'b0);
    r0 = n_reg; e0 = n_ce;
    run_game(1, 2000, fin, esp_max, bad);
    n_chk++;
    if (fin !== 4'hE) $display("FAIL err_state: got %h want E", fin); else n_pass++;
    n_chk++;
    if ({pronto, ganhou, perdeu, db_timeout} !== 4'b1010)
      $display("FAIL err_flags: got %b want 1010", {pronto, ganhou, perdeu, db_timeout});
    else n_pass++;
    n_chk++;
    if (n_ce - e0 != 1) $display("FAIL err_contaE: got %0d want 1", n_ce - e0); else n_pass++;
    n_chk++;
    if (n_reg - r0 != 3) $display("FAIL err_registraR: got %0d want 3", n_reg - r0);
    else n_pass++;
    repeat (5) @(negedge clock);
    n_chk++;
    if ({db_estado, pronto, perdeu} !== 6'b1110_11)
      $display("FAIL err_hold: got %b want 111011", {db_estado, pronto, perdeu});
    else n_pass++;
    err_en = 1'b0;
  endtask

  task automatic test_timeout();
    logic [3:0] fin;
    int esp_max, bad;
    start_game(1'b0);
    run_game(0, 200, fin, esp_max, bad);
    n_chk++;
    if (fin !== 4'hD) $display("FAIL to_state: got %h want D", fin); else n_pass++;
    n_chk++;
    if (esp_max != 20) $display("FAIL to_cycles: got %0d want 20", esp_max); else n_pass++;
    n_chk++;
    if ({pronto, ganhou, perdeu, db_timeout} !== 4'b1011)
      $display("FAIL to_flags: got %b want 1011", {pronto, ganhou, perdeu, db_timeout});
    else n_pass++;
  endtask

  task automatic test_restart_long();
    logic [3:0] fin;
    int esp_max, bad, r0, s0;
    r0 = n_reg; s0 = n_cs;
    start_game(1'b1);
    n_chk++;
    if (db_estado !== 4'h1) $display("FAIL restart_state: got %h want 1", db_estado);
    else n_pass++;
    n_chk++;
    if ({pronto, perdeu, db_timeout} !== 3'b000)
      $display("FAIL restart_clear: got %b want 000", {pronto, perdeu, db_timeout});
    else n_pass++;
    @(negedge clock);
    nivel = 1'b0;
    run_game(1, 3000, fin, esp_max, bad);
    n_chk++;
    if (fin !== 4'hA) $display("FAIL long_state: got %h want A", fin); else n_pass++;
    n_chk++;
    if (n_cs - s0 != 5) $display("FAIL long_contaS: got %0d want 5", n_cs - s0); else n_pass++;
    n_chk++;
    if (n_reg - r0 != 21) $display("FAIL long_registraR: got %0d want 21", n_reg - r0);
    else n_pass++;
  endtask

  task automatic test_timeout_boundary();
    logic [3:0] fin;
    int esp_max, bad, r0;
    start_game(1'b0);
    r0 = n_reg;
    run_game(20, 3000, fin, esp_max, bad);
    n_chk++;
    if (fin !== 4'hA) $display("FAIL bound_state: got %h want A", fin); else n_pass++;
    n_chk++;
    if (bad != 0) $display("FAIL bound_registra: got %0d misses want 0", bad); else n_pass++;
    n_chk++;
    if (n_reg - r0 != 10) $display("FAIL bound_registraR: got %0d want 10", n_reg - r0);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic found;
    found = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({db_estado, pronto, ganhou} !== 6'b0)
      $display("FAIL areset_final: got %b want 0", {db_estado, pronto, ganhou});
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    start_game(1'b0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (db_estado == 4'h5) begin
        found = 1'b1;
        break;
      end
      if (db_estado == 4'h3) jogada = 1'b1;
      else jogada = 1'b0;
    end
    jogada = 1'b0;
    n_chk++;
    if (found !== 1'b1) $display("FAIL areset_reach: got %b want 1", found); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({db_estado, zeraE, contaE, zeraS, contaS, zeraR, registraR, pronto, ganhou, perdeu,
         db_timeout} !== 14'b0)
      $display("FAIL areset_compara: got %b want 0", {db_estado, zeraE, contaE, zeraS,
               contaS, zeraR, registraR, pronto, ganhou, perdeu, db_timeout});
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_chk++;
    if (db_estado !== 4'h0) $display("FAIL areset_idle: got %h want 0", db_estado);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_short_win();
    test_error();
    test_timeout();
    test_restart_long();
    test_timeout_boundary();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
- Control unit (FSM plus timeout timer) that sequences the memory-game datapath of circuito_exp5.
- Drives the address counter (E), sequence-length counter (S) and play register (R), and decides win, loss and timeout.
- Selects the game length from nivel, which is latched when a game starts.
- Sits between the top level (jogar, nivel) and the datapath status flags.

Parameters:
- TIMEOUT_CICLOS, 3000, clock cycles allowed per play (3 s at 1 kHz).
- TW, 12, width of the internal timeout counter; must satisfy 2^TW >= TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- jogar  in  1  start request, level-sensitive, sampled each clock.
- nivel  in  1  1 = long game (fimS_long), 0 = short game (fimS_short); latched on start.
- jogada  in  1  one-cycle pulse from the datapath edge detector: a button was pressed.
- igual  in  1  registered play equals the memory word at the current address.
- fimE  in  1  address counter equals the sequence counter (enderecoIgualSequencia).
- fimS_long  in  1  sequence counter at its last position, long game.
- fimS_short  in  1  sequence counter at its last position, short game.
- zeraE, contaE, zeraS, contaS, zeraR, registraR  out  1 each  datapath controls.
- pronto  out  1  game finished.
- ganhou  out  1  game finished by winning.
- perdeu  out  1  game finished by a wrong play or a timeout.
- db_timeout  out  1  the game ended by timeout.
- db_estado  out  4  state code, for the display.

Behaviour:
- Moore FSM. All outputs are decoded from the state only, except that zeraE and zeraS are also asserted in preparacao.
- Reset (reset=0):
  - state goes to inicial;
  - timer goes to 0;
  - the latched nivel goes to 0;
  - all outputs go to 0, and db_estado=0.
- State codes: inicial=0, preparacao=1, nova_seq=2, espera=3, registra=4, compara=5, proximo=6, prox_seq=7, fim_acerto=A, fim_erro=E, fim_timeout=D.
- inicial: if jogar=1, go to preparacao, otherwise stay.
- preparacao: assert zeraE, zeraS and zeraR; latch nivel. Go to nova_seq.
- nova_seq: assert zeraE. Go to espera.
- espera:
  - Timer increments every cycle. It is cleared in every other state, so it restarts each time espera is entered.
  - If jogada=1, go to registra. jogada takes priority over a timeout in the same cycle.
  - Else if timer == TIMEOUT_CICLOS-1, go to fim_timeout. A play therefore times out after exactly TIMEOUT_CICLOS cycles in espera.
- registra: assert registraR (one cycle). Go to compara.
- compara: the outcome is decided in this order:
  - igual=0: go to fim_erro;
  - igual=1 and fimE=0: go to proximo;
  - igual=1 and fimE=1 and the selected fimS=1: go to fim_acerto;
  - otherwise: go to prox_seq.
- proximo: assert contaE. Go to espera.
- prox_seq: assert contaS. Go to nova_seq.
- fim_acerto: pronto=1 and ganhou=1.
- fim_erro: pronto=1 and perdeu=1.
- fim_timeout: pronto=1, perdeu=1 and db_timeout=1.
- All final states hold while jogar=0. jogar=1 goes to preparacao; there is no return to inicial without reset.
- pronto, ganhou, perdeu and db_timeout hold for as long as the final state is held. They clear in the cycle after leaving it.
- jogar is ignored in every non-final state other than inicial.
- nivel changes mid-game have no effect.
- reset=0 in any state aborts immediately: outputs return to 0 without waiting for a clock edge.
- Undefined state codes go to inicial on the next clock.
- Latencies:
  - from registra to the first cycle of espera for the next play: 3 cycles (registra, compara, proximo);
  - from registra to the first cycle of espera for a new round: 4 cycles (registra, compara, prox_seq, nova_seq).

Test Plan:
- Reset, then idle: with reset=0 for 1 cycle and then 10 idle cycles, db_estado=0 and all outputs are 0. jogar=1 for 5 cycles gives db_estado 1 → 2 → 3.
- Short-game win (TIMEOUT_CICLOS=20, nivel=0):
  - the bench model drives igual=1 on every play, fimE at the end of each round, and fimS_short on round 4;
  - required: db_estado=A, pronto=1, ganhou=1, perdeu=0;
  - contaS pulses 3 times, and registraR pulses 1+2+3+4=10 times.
- Error on round 2, play 2: with igual=0 in compara, db_estado=E, pronto=1, perdeu=1, db_timeout=0, and no contaE pulse after compara.
- Timeout: no jogada for 20 cycles in espera gives fim_timeout (D), with perdeu=1 and db_timeout=1 exactly 20 cycles after entry to espera.
- Timeout boundary: jogada in cycle 20 of espera (timer=19) goes to registra, not D. The timer restarts on the next espera, and the game continues.
- Restart and asynchronous reset:
  - jogar=1 in state D goes to preparacao, latching the new nivel=1; the long game then needs fimS_long;
  - reset=0 mid-compara clears all outputs before the next edge, with db_estado=0.
